collision_ctrl: RTL and testbench

COLLISION_CTRL -- requirements
Module: collision_ctrl

---
 rtl/flappy_pkg.sv | 21 ++
 rtl/flap_sync.sv | 17 +
 rtl/collision_ctrl.sv | 101 ++++++++++
 tb/tb_collision_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: game states and geometry/physics defaults shared by collision, tube and render blocks
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int DEF_BIRD_X   = 300;
    localparam int DEF_BIRD_SZ  = 20;
    localparam int DEF_TUBE_W   = 60;
    localparam int DEF_GAP_HALF = 50;
    localparam int DEF_Y_GROUND = 460;
    localparam int DEF_GRAVITY  = 1;
    localparam int DEF_FLAP_V   = 12;
    localparam int DEF_MAX_FALL = 10;
    localparam int Y_START      = 240;

endpackage

// File: rtl/flap_sync.sv
// flap_sync: two-flop synchroniser for the raw button plus a one-tick rising-edge pulse
module flap_sync (
    input  logic clk10,
    input  logic clr,
    input  logic flap,
    output logic flap_evt
);

    logic [2:0] sr;

    always_ff @(posedge clk10)
        if (!clr) sr <= '0;
        else      sr <= {sr[1:0], flap};

    assign flap_evt = sr[1] & ~sr[2];

endmodule

// File: rtl/collision_ctrl.sv
// collision_ctrl: bird physics, tube/ground collision and the game state machine
module collision_ctrl
    import flappy_pkg::*;
#(
    parameter int BIRD_X   = DEF_BIRD_X,
    parameter int BIRD_SZ  = DEF_BIRD_SZ,
    parameter int TUBE_W   = DEF_TUBE_W,
    parameter int GAP_HALF = DEF_GAP_HALF,
    parameter int Y_GROUND = DEF_Y_GROUND,
    parameter int GRAVITY  = DEF_GRAVITY,
    parameter int FLAP_V   = DEF_FLAP_V,
    parameter int MAX_FALL = DEF_MAX_FALL
) (
    input  logic       clk10,
    input  logic       clr,
    input  logic       flap,
    input  logic [9:0] tube1_x_pos,
    input  logic [9:0] tube2_x_pos,
    input  logic [9:0] tube3_x_pos,
    input  logic [9:0] tube1_y_pos,
    input  logic [9:0] tube2_y_pos,
    input  logic [9:0] tube3_y_pos,
    output logic [9:0] bird_y_pos,
    output logic       game_end,
    output logic [1:0] state
);

    localparam logic [9:0]        Y_MAX  = 10'(Y_GROUND - BIRD_SZ);
    localparam logic signed [7:0] V_FLAP = 8'(-FLAP_V);
    localparam logic signed [7:0] V_G    = 8'(GRAVITY);
    localparam logic signed [7:0] V_MAX  = 8'(MAX_FALL);

    state_t            st;
    logic signed [7:0] vel, v_grav, v_new, v_next;
    logic signed [10:0] y_sum;
    logic [9:0]        y_next;
    logic              flap_evt, hit, flap_go, ground;

    // tube_x - TUBE_W and tube_y - GAP_HALF deliberately wrap in 11 bits
    function automatic logic tube_hit(input logic [9:0] tx, input logic [9:0] ty, input logic [9:0] by);
        logic [10:0] x, y, b;
        x = {1'b0, tx};
        y = {1'b0, ty};
        b = {1'b0, by};
        return (11'(BIRD_X + BIRD_SZ) > x - 11'(TUBE_W)) && (11'(BIRD_X) < x)
            && !((b >= y - 11'(GAP_HALF)) && (b + 11'(BIRD_SZ) <= y + 11'(GAP_HALF)));
    endfunction

    flap_sync u_sync (
        .clk10    (clk10),
        .clr      (clr),
        .flap     (flap),
        .flap_evt (flap_evt)
    );

    always_comb begin
        hit     = (st == PLAY) && (tube_hit(tube1_x_pos, tube1_y_pos, bird_y_pos)
                               || tube_hit(tube2_x_pos, tube2_y_pos, bird_y_pos)
                               || tube_hit(tube3_x_pos, tube3_y_pos, bird_y_pos));
        flap_go = flap_evt && ((st == IDLE) || (st == PLAY && !hit));
        v_grav  = (vel + V_G > V_MAX) ? V_MAX : vel + V_G;
        v_new   = flap_go ? V_FLAP : v_grav;
        y_sum   = $signed({1'b0, bird_y_pos}) + $signed({{3{v_new[7]}}, v_new});
        y_next  = (y_sum < 0) ? '0 : (y_sum > $signed({1'b0, Y_MAX})) ? Y_MAX : y_sum[9:0];
        v_next  = (y_sum < 0) ? '0 : v_new;
        ground  = y_next == Y_MAX;
    end

    always_ff @(posedge clk10) begin
        if (!clr) begin
            st         <= IDLE;
            bird_y_pos <= 10'(Y_START);
            vel        <= '0;
            game_end   <= 1'b1;
        end else begin
            case (st)
                IDLE: if (flap_evt) begin
                    st         <= PLAY;
                    bird_y_pos <= y_next;
                    vel        <= v_next;
                    game_end   <= 1'b0;
                end
                PLAY: begin
                    st         <= ground ? OVER : hit ? DEAD : PLAY;
                    bird_y_pos <= y_next;
                    vel        <= v_next;
                    game_end   <= ground || hit;
                end
                DEAD: begin
                    st         <= ground ? OVER : DEAD;
                    bird_y_pos <= y_next;
                    vel        <= v_next;
                end
                default: ;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_collision_ctrl.sv
// tb_collision_ctrl: directed scenarios plus randomized play checked against a behavioural game model
module tb_collision_ctrl;

    logic       clk10 = 1'b0;
    logic       clr   = 1'b0;
    logic       flap  = 1'b0;
    logic [9:0] t1x, t1y, t2x, t2y, t3x, t3y;
    logic [9:0] bird_y_pos;
    logic       game_end;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    int m_st, m_y, m_v, m_ge;
    int fh[3];

    always #5 clk10 = ~clk10;

    collision_ctrl dut (
        .clk10       (clk10),
        .clr         (clr),
        .flap        (flap),
        .tube1_x_pos (t1x),
        .tube2_x_pos (t2x),
        .tube3_x_pos (t3x),
        .tube1_y_pos (t1y),
        .tube2_y_pos (t2y),
        .tube3_y_pos (t3y),
        .bird_y_pos  (bird_y_pos),
        .game_end    (game_end),
        .state       (state)
    );

    function automatic bit m_hit(int tx, int ty, int by);
        int left, gap_top;
        left    = (tx - 60) & 2047;
        gap_top = (ty - 50) & 2047;
        return (320 > left) && (300 < tx) && !((by >= gap_top) && (by + 20 <= ty + 50));
    endfunction

    task automatic model_edge();
        bit evt, hit, go;
        int v, s;
        if (!clr) begin
            m_st = 0; m_y = 240; m_v = 0; m_ge = 1;
            fh = '{default: 0};
            return;
        end
        evt = fh[1] && !fh[2];
        fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = int'(flap);
        if (m_st == 3 || (m_st == 0 && !evt)) return;
        hit = (m_st == 1) && (m_hit(t1x, t1y, m_y) || m_hit(t2x, t2y, m_y) || m_hit(t3x, t3y, m_y));
        go  = evt && (m_st == 0 || (m_st == 1 && !hit));
        v   = go ? -12 : ((m_v + 1 > 10) ? 10 : m_v + 1);
        s   = m_y + v;
        if (s < 0) begin m_y = 0; m_v = 0; end
        else if (s > 440) begin m_y = 440; m_v = v; end
        else begin m_y = s; m_v = v; end
        if (m_st == 0) m_st = 1;
        else if (m_y == 440) m_st = 3;
        else if (hit) m_st = 2;
        m_ge = (m_st != 1) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge clk10);
        model_edge();
        @(negedge clk10);
    endtask

    task automatic set_far();
        t1x = '0; t2x = '0; t3x = '0;
        t1y = 10'd240; t2y = 10'd240; t3y = 10'd240;
    endtask

    task automatic do_reset();
        clr = 1'b0; flap = 1'b0; set_far();
        step();
        clr = 1'b1;
    endtask

    task automatic start_game();
        flap = 1'b1;
        repeat (3) step();
        flap = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b0; flap = 1'b1; set_far();
        step();
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd0, 1'b1, 10'd240}) begin
            n_fail++;
            $display("FAIL reset_state: got st=%0d ge=%0d y=%0d want st=0 ge=1 y=240", state, game_end, bird_y_pos);
        end
        clr = 1'b1; flap = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd0, 1'b1, 10'd240}) begin
            n_fail++;
            $display("FAIL idle_hold: got st=%0d ge=%0d y=%0d want st=0 ge=1 y=240", state, game_end, bird_y_pos);
        end
    endtask

    task automatic test_start();
        do_reset();
        flap = 1'b1;
        step(); step();
        n_tests++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL start_latency: got st=%0d after 2 edges want st=0", state);
        end
        step();
        flap = 1'b0;
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd1, 1'b0, 10'd228}) begin
            n_fail++;
            $display("FAIL start_play: got st=%0d ge=%0d y=%0d want st=1 ge=0 y=228", state, game_end, bird_y_pos);
        end
    endtask

    task automatic test_fall();
        int k = 0;
        int tens = 0;
        int prev;
        while (state !== 2'd3 && k < 100) begin
            prev = m_y;
            step();
            k++;
            if (m_y - prev == 10) tens++;
            n_tests++;
            if ({state, game_end, bird_y_pos} !== {2'(m_st), 1'(m_ge), 10'(m_y)}) begin
                n_fail++;
                $display("FAIL fall_step%0d: got st=%0d ge=%0d y=%0d want st=%0d ge=%0d y=%0d",
                         k, state, game_end, bird_y_pos, m_st, m_ge, m_y);
            end
        end
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd3, 1'b1, 10'd440} || tens < 3) begin
            n_fail++;
            $display("FAIL ground_over: got st=%0d ge=%0d y=%0d tens=%0d want st=3 ge=1 y=440 tens>=3",
                     state, game_end, bird_y_pos, tens);
        end
        for (int i = 0; i < 6; i++) begin
            flap = i[0];
            step();
        end
        flap = 1'b0;
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd3, 1'b1, 10'd440}) begin
            n_fail++;
            $display("FAIL over_hold: got st=%0d ge=%0d y=%0d want st=3 ge=1 y=440", state, game_end, bird_y_pos);
        end
    endtask

    task automatic test_gap_hit();
        int xs[6]  = '{330, 330, 300, 380, 379, 0};
        int dys[6] = '{50, -30, 800, 800, 800, 0};
        int exp[6] = '{1, 1, 1, 1, 2, 2};
        do_reset();
        start_game();
        step();
        for (int i = 0; i < 6; i++) begin
            t1x = 10'(xs[i]);
            t1y = (dys[i] == 800) ? 10'd1000 : 10'(m_y + dys[i]);
            step();
            n_tests++;
            if ({state, game_end, bird_y_pos} !== {2'(m_st), 1'(m_ge), 10'(m_y)} || state !== 2'(exp[i])) begin
                n_fail++;
                $display("FAIL gap_hit%0d: got st=%0d ge=%0d y=%0d want st=%0d ge=%0d y=%0d",
                         i, state, game_end, bird_y_pos, exp[i], m_ge, m_y);
            end
        end
        n_tests++;
        if (game_end !== 1'b1) begin
            n_fail++;
            $display("FAIL dead_game_end: got ge=%0d want ge=1", game_end);
        end
    endtask

    task automatic test_hit_flap();
        int prev, want, k;
        do_reset();
        start_game();
        repeat (3) step();
        flap = 1'b1;
        step(); step();
        t1x = 10'd330; t1y = 10'd1000;
        prev = m_y;
        want = prev + ((m_v + 1 > 10) ? 10 : m_v + 1);
        step();
        set_far();
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd2, 1'b1, 10'(want)}) begin
            n_fail++;
            $display("FAIL hit_beats_flap: got st=%0d ge=%0d y=%0d want st=2 ge=1 y=%0d",
                     state, game_end, bird_y_pos, want);
        end
        k = 0;
        while (state !== 2'd3 && k < 100) begin
            flap = k[0];
            step();
            k++;
            n_tests++;
            if ({state, game_end, bird_y_pos} !== {2'(m_st), 1'(m_ge), 10'(m_y)}) begin
                n_fail++;
                $display("FAIL dead_fall%0d: got st=%0d ge=%0d y=%0d want st=%0d ge=%0d y=%0d",
                         k, state, game_end, bird_y_pos, m_st, m_ge, m_y);
            end
        end
        flap = 1'b0;
        n_tests++;
        if ({state, bird_y_pos} !== {2'd3, 10'd440}) begin
            n_fail++;
            $display("FAIL dead_to_over: got st=%0d y=%0d want st=3 y=440", state, bird_y_pos);
        end
    endtask

    task automatic test_ceiling();
        do_reset();
        start_game();
        for (int k = 0; k < 60; k++) begin
            flap = (k % 2 == 0);
            step();
            n_tests++;
            if ({state, game_end, bird_y_pos} !== {2'(m_st), 1'(m_ge), 10'(m_y)}) begin
                n_fail++;
                $display("FAIL climb%0d: got st=%0d ge=%0d y=%0d want st=%0d ge=%0d y=%0d",
                         k, state, game_end, bird_y_pos, m_st, m_ge, m_y);
            end
            if (bird_y_pos === 10'd0) break;
        end
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd1, 1'b0, 10'd0}) begin
            n_fail++;
            $display("FAIL ceiling_clamp: got st=%0d ge=%0d y=%0d want st=1 ge=0 y=0", state, game_end, bird_y_pos);
        end
        flap = 1'b0;
        repeat (4) begin
            step();
            n_tests++;
            if ({state, game_end, bird_y_pos} !== {2'(m_st), 1'(m_ge), 10'(m_y)}) begin
                n_fail++;
                $display("FAIL after_ceiling: got st=%0d ge=%0d y=%0d want st=%0d ge=%0d y=%0d",
                         state, game_end, bird_y_pos, m_st, m_ge, m_y);
            end
        end
    endtask

    task automatic test_reset_dead();
        do_reset();
        start_game();
        step();
        t1x = 10'd330; t1y = 10'd1000;
        step();
        n_tests++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL enter_dead: got st=%0d want st=2", state);
        end
        flap = 1'b1; clr = 1'b0;
        step();
        n_tests++;
        if ({state, game_end, bird_y_pos} !== {2'd0, 1'b1, 10'd240}) begin
            n_fail++;
            $display("FAIL reset_in_dead: got st=%0d ge=%0d y=%0d want st=0 ge=1 y=240", state, game_end, bird_y_pos);
        end
        clr = 1'b1; flap = 1'b0; set_far();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            clr  = ($urandom_range(0, 79) != 0);
            flap = ($urandom_range(0, 2) == 0);
            if (k % 16 == 0) begin
                t1x = 10'($urandom_range(240, 420));
                t1y = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(0, 1023))
                                                   : 10'((m_y + $urandom_range(0, 100)) % 1024);
                t2x = 10'($urandom_range(0, 1023));
                t2y = 10'($urandom_range(0, 1023));
                t3x = 10'($urandom_range(0, 1023));
                t3y = 10'($urandom_range(0, 1023));
            end
            step();
            n_tests++;
            if ({state, game_end, bird_y_pos} !== {2'(m_st), 1'(m_ge), 10'(m_y)}) begin
                n_fail++;
                $display("FAIL random%0d: got st=%0d ge=%0d y=%0d want st=%0d ge=%0d y=%0d",
                         k, state, game_end, bird_y_pos, m_st, m_ge, m_y);
            end
        end
    endtask

    initial begin
        set_far();
        m_st = 0; m_y = 240; m_v = 0; m_ge = 1;
        fh = '{default: 0};
        @(negedge clk10);
        test_reset();
        test_start();
        test_fall();
        test_gap_hit();
        test_hit_flap();
        test_ceiling();
        test_reset_dead();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1, "watchdog timeout");
    end

endmodule
